arb_mux_nto1: RTL and testbench

ARB_MUX_NTO1 -- requirements
Module: arb_mux_nto1

---
 rtl/arb_mux_nto1.sv | 118 +++++++++++
 tb/tb_arb_mux_nto1.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_nto1.sv
// rtl/arb_mux_nto1.sv - N-to-1 registered mux with direct select or round-robin arbitration
module arb_mux_nto1 #(
    parameter int DWIDTH = 32,
    parameter int NCH    = 4,
    localparam int SELW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic [SELW-1:0]       sel,
    input  logic [NCH-1:0]        in_valid,
    input  logic [NCH*DWIDTH-1:0] in_data,
    output logic [NCH-1:0]        in_ready,
    output logic                  out_valid,
    output logic [DWIDTH-1:0]     out_data,
    output logic [SELW-1:0]       out_grant,
    input  logic                  out_ready
);

    logic                  r_out_valid;
    logic [DWIDTH-1:0]     r_out_data;
    logic [SELW-1:0]       r_out_grant;
    logic [SELW-1:0]       r_ptr;

    logic                  w_load_en;
    logic                  w_dir_vld;
    logic [SELW-1:0]       w_dir_idx;
    logic                  w_rr_vld;
    logic [SELW-1:0]       w_rr_idx;
    logic                  w_gnt_vld;
    logic [SELW-1:0]       w_gnt_idx;
    logic                  w_xfer;
    logic [SELW-1:0]       w_ptr_nxt;
    logic [DWIDTH-1:0]     w_gnt_data;
    logic [NCH-1:0]        w_ready;

    assign w_load_en = !r_out_valid || out_ready;

    // An out-of-range sel simply never matches any channel index.
    always_comb begin
        w_dir_vld = 1'b0;
        w_dir_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (sel == SELW'(i) && in_valid[i]) begin
                w_dir_vld = 1'b1;
                w_dir_idx = SELW'(i);
            end
        end
    end

    // First pass covers ptr..NCH-1, second pass wraps to 0..ptr-1.
    always_comb begin
        w_rr_vld = 1'b0;
        w_rr_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (!w_rr_vld && (i >= int'(r_ptr)) && in_valid[i]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = SELW'(i);
            end
        end
        for (int i = 0; i < NCH; i++) begin
            if (!w_rr_vld && in_valid[i]) begin
                w_rr_vld = 1'b1;
                w_rr_idx = SELW'(i);
            end
        end
    end

    assign w_gnt_vld = mode ? w_rr_vld : w_dir_vld;
    assign w_gnt_idx = mode ? w_rr_idx : w_dir_idx;
    assign w_xfer    = w_load_en && w_gnt_vld;
    assign w_ptr_nxt = (w_gnt_idx == SELW'(NCH - 1)) ? '0 : w_gnt_idx + SELW'(1);

    // Only the granted lane is ever selected, so unknowns elsewhere stay out.
    always_comb begin
        w_gnt_data = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_data = in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (w_xfer && rst_n && (w_gnt_idx == SELW'(i))) begin
                w_ready[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_grant <= '0;
            r_ptr       <= '0;
        end else if (w_load_en) begin
            if (w_gnt_vld) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_gnt_data;
                r_out_grant <= w_gnt_idx;
                if (mode) begin
                    r_ptr <= w_ptr_nxt;
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_grant = r_out_grant;

endmodule

// File: tb/tb_arb_mux_nto1.sv
// tb/tb_arb_mux_nto1.sv - bench for arb_mux_nto1 with NCH=4 and NCH=3 instances
module tb_arb_mux_nto1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst4_n, mode4, ordy4, ov4;
    logic [1:0]   sel4, og4;
    logic [3:0]   iv4, ir4;
    logic [127:0] data4;
    logic [31:0]  od4;

    logic         rst3_n, mode3, ordy3, ov3;
    logic [1:0]   sel3, og3;
    logic [2:0]   iv3, ir3;
    logic [95:0]  data3;
    logic [31:0]  od3;

    arb_mux_nto1 #(.DWIDTH(32), .NCH(4)) u4 (
        .clk(clk), .rst_n(rst4_n), .mode(mode4), .sel(sel4), .in_valid(iv4),
        .in_data(data4), .in_ready(ir4), .out_valid(ov4), .out_data(od4),
        .out_grant(og4), .out_ready(ordy4)
    );

    arb_mux_nto1 #(.DWIDTH(32), .NCH(3)) u3 (
        .clk(clk), .rst_n(rst3_n), .mode(mode3), .sel(sel3), .in_valid(iv3),
        .in_data(data3), .in_ready(ir3), .out_valid(ov3), .out_data(od3),
        .out_grant(og3), .out_ready(ordy3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       mode;
        logic [1:0] sel;
        logic [3:0] iv;
        logic       ordy;
        logic [3:0] exp_ir;
        logic       exp_ov;
        logic [1:0] exp_og;
    } vec_t;

    vec_t        tbl[18];
    logic [31:0] ch4[4];
    logic [31:0] ch3[3];

    int          m_ptr[2];
    int          m_ov[2];
    int          m_og[2];
    logic [31:0] m_od[2];

    function automatic int model_grant(input logic md, input int sl, input logic [3:0] ivr,
                                       input int ptr, input int n);
        if (!md) begin
            if (sl < n && ivr[sl]) return sl;
            return -1;
        end
        for (int k = 0; k < n; k++) begin
            if (ivr[(ptr + k) % n]) return (ptr + k) % n;
        end
        return -1;
    endfunction

    task automatic rand_run(input int d, input int cycles);
        int          n, g;
        logic [3:0]  ivr, ir_exp, ir_act;
        logic [31:0] w[4];
        logic        md, rdy, ld;
        logic [1:0]  sl;
        n = (d == 0) ? 4 : 3;
        for (int c = 0; c < cycles; c++) begin
            chk($sformatf("rnd%0d_c%0d_ov", d, c), (d == 0) ? ov4 : ov3, 64'(m_ov[d]));
            chk($sformatf("rnd%0d_c%0d_og", d, c), (d == 0) ? og4 : og3, 64'(m_og[d]));
            chk($sformatf("rnd%0d_c%0d_od", d, c), (d == 0) ? od4 : od3, 64'(m_od[d]));
            md  = 1'($urandom_range(0, 1));
            sl  = 2'($urandom_range(0, 3));
            ivr = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            if (n == 3) ivr[3] = 1'b0;
            rdy = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) w[k] = $urandom;
            if (d == 0) begin
                mode4 = md; sel4 = sl; iv4 = ivr; ordy4 = rdy;
                data4 = {w[3], w[2], w[1], w[0]};
            end else begin
                mode3 = md; sel3 = sl; iv3 = ivr[2:0]; ordy3 = rdy;
                data3 = {w[2], w[1], w[0]};
            end
            #1;
            g      = model_grant(md, int'(sl), ivr, m_ptr[d], n);
            ld     = (m_ov[d] == 0) || rdy;
            ir_exp = (g >= 0 && ld) ? 4'(1 << g) : 4'b0;
            ir_act = (d == 0) ? ir4 : {1'b0, ir3};
            chk($sformatf("rnd%0d_c%0d_ir", d, c), ir_act, ir_exp);
            if (ld) begin
                if (g >= 0) begin
                    m_ov[d] = 1;
                    m_od[d] = w[g];
                    m_og[d] = g;
                    if (md) m_ptr[d] = (g + 1) % n;
                end else begin
                    m_ov[d] = 0;
                end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic step3(input logic md, input logic [1:0] sl, input logic [2:0] ivr,
                         input logic rdy, input logic [2:0] exp_ir, input logic exp_ov,
                         input logic [1:0] exp_og, input string name);
        mode3 = md; sel3 = sl; iv3 = ivr; ordy3 = rdy;
        #1;
        chk({name, "_ir"}, ir3, exp_ir);
        @(posedge clk); #1;
        chk({name, "_ov"}, ov3, exp_ov);
        chk({name, "_og"}, og3, exp_og);
        if (exp_ov) chk({name, "_od"}, od3, ch3[exp_og]);
    endtask

    initial begin
        ch4[0] = 32'h1111_0000; ch4[1] = 32'h2222_1111;
        ch4[2] = 32'hDEAD_BEEF; ch4[3] = 32'h4444_3333;
        ch3[0] = 32'hAAAA_0000; ch3[1] = 32'hBBBB_1111; ch3[2] = 32'hCCCC_2222;

        tbl[0]  = '{1'b0, 2'd2, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[1]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[2]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[3]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[4]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[5]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd0};
        tbl[6]  = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[7]  = '{1'b0, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd1};
        tbl[8]  = '{1'b0, 2'd3, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[9]  = '{1'b1, 2'd3, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd2};
        tbl[10] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[11] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[12] = '{1'b1, 2'd0, 4'b1111, 1'b0, 4'b0000, 1'b1, 2'd2};
        tbl[13] = '{1'b1, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd3};
        tbl[14] = '{1'b0, 2'd2, 4'b1011, 1'b0, 4'b0000, 1'b1, 2'd3};
        tbl[15] = '{1'b0, 2'd2, 4'b1011, 1'b1, 4'b0000, 1'b0, 2'd3};
        tbl[16] = '{1'b1, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd3};
        tbl[17] = '{1'b1, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1};

        rst4_n = 1'b0; rst3_n = 1'b0;
        mode4 = 1'b1; sel4 = 2'd0; iv4 = 4'hF; ordy4 = 1'b1;
        data4 = {ch4[3], ch4[2], ch4[1], ch4[0]};
        mode3 = 1'b1; sel3 = 2'd0; iv3 = 3'b000; ordy3 = 1'b1;
        data3 = {ch3[2], ch3[1], ch3[0]};
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ir4", ir4, 4'b0);
        chk("rst_ov4", ov4, 1'b0);
        chk("rst_od4", od4, 32'h0);
        chk("rst_og4", og4, 2'd0);
        rst4_n = 1'b1; rst3_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            mode4 = tbl[i].mode; sel4 = tbl[i].sel; iv4 = tbl[i].iv; ordy4 = tbl[i].ordy;
            #1;
            chk($sformatf("row%0d_ir", i), ir4, tbl[i].exp_ir);
            @(posedge clk); #1;
            chk($sformatf("row%0d_ov", i), ov4, tbl[i].exp_ov);
            chk($sformatf("row%0d_og", i), og4, tbl[i].exp_og);
            chk($sformatf("row%0d_od", i), od4, ch4[tbl[i].exp_og]);
        end

        rst4_n = 1'b0;
        #1;
        chk("midrst4_ov", ov4, 1'b0);
        chk("midrst4_od", od4, 32'h0);
        chk("midrst4_og", og4, 2'd0);
        chk("midrst4_ir", ir4, 4'b0);
        @(posedge clk); #1;
        rst4_n = 1'b1;

        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0, "n3_rr0");
        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2, "n3_rr1");
        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0, "n3_rr2");
        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b100, 1'b1, 2'd2, "n3_rr3");
        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0, "n3_rr4");
        step3(1'b1, 2'd0, 3'b101, 1'b0, 3'b000, 1'b1, 2'd0, "n3_stall0");
        step3(1'b1, 2'd0, 3'b101, 1'b0, 3'b000, 1'b1, 2'd0, "n3_stall1");
        rst3_n = 1'b0;
        #1;
        chk("n3_midrst_ov", ov3, 1'b0);
        chk("n3_midrst_od", od3, 32'h0);
        chk("n3_midrst_og", og3, 2'd0);
        chk("n3_midrst_ir", ir3, 3'b000);
        @(posedge clk); #1;
        rst3_n = 1'b1;
        step3(1'b1, 2'd0, 3'b101, 1'b1, 3'b001, 1'b1, 2'd0, "n3_postrst");
        step3(1'b0, 2'd3, 3'b111, 1'b1, 3'b000, 1'b0, 2'd0, "n3_sel3");

        rst4_n = 1'b0; rst3_n = 1'b0;
        @(posedge clk); #1;
        rst4_n = 1'b1; rst3_n = 1'b1;
        for (int d = 0; d < 2; d++) begin
            m_ptr[d] = 0; m_ov[d] = 0; m_og[d] = 0; m_od[d] = 32'h0;
        end
        rand_run(0, 400);
        rand_run(1, 400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
